// File: rtl/sm_pulse_monitor_pkg.sv
// Shared FSM encoding and default sizing for the stepper-motor pulse monitor.
package sm_pulse_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } sm_state_e;

    localparam int unsigned SM_SIZE          = 32'd16;
    localparam int unsigned SM_N             = 32'd100;
    localparam int unsigned SM_NUM_PERIOD    = 32'd2000;
    // Stall is declared after four nominal periods without a rising edge.
    localparam int unsigned SM_TIMEOUT_RATIO = 32'd4;

endpackage

// File: rtl/sm_pulse_monitor_edge_sync.sv
// Brings the asynchronous step line into the clk domain, applies polarity and
// produces level plus one-cycle rise/fall strobes, all three clk after the pin edge.
module sm_pulse_monitor_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    input  logic invert_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic line_q;
    logic line_prev_q;

    // Two-flop synchroniser, polarity fix-up, then one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            line_q      <= 1'b0;
            line_prev_q <= 1'b0;
        end else begin
            sync1_q     <= pulse_i;
            sync2_q     <= sync1_q;
            line_q      <= sync2_q ^ invert_i;
            line_prev_q <= line_q;
        end
    end

    assign level_o = line_q;
    assign rise_o  = line_q & ~line_prev_q;
    assign fall_o  = ~line_q & line_prev_q;

endmodule

// File: rtl/sm_pulse_monitor.sv
// Step-train monitor: edge count, period, high width, N-pulse completion and stall detection.
module sm_pulse_monitor
    import sm_pulse_monitor_pkg::*;
#(
    parameter int unsigned SIZE    = SM_SIZE,
    parameter int unsigned N       = SM_N,
    parameter int unsigned TIMEOUT = SM_TIMEOUT_RATIO * SM_NUM_PERIOD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pulse_in,
    input  logic            invert_pulse,
    input  logic            clr,
    input  logic [SIZE-1:0] n_target,
    output logic [SIZE-1:0] count,
    output logic [SIZE-1:0] period,
    output logic [SIZE-1:0] width,
    output logic            meas_valid,
    output logic            moving,
    output logic            n_done,
    output logic            stall
);

    localparam logic [SIZE-1:0] ONES_C    = '1;
    localparam logic [SIZE-1:0] ONE_C     = SIZE'(32'd1);
    localparam logic [SIZE-1:0] N_C       = SIZE'(N);
    localparam logic [SIZE-1:0] TIMEOUT_C = SIZE'(TIMEOUT);

    logic            line_s;
    logic            rise_s;
    logic            fall_s;
    logic [SIZE-1:0] target_s;
    logic [SIZE-1:0] count_inc_s;
    logic [SIZE-1:0] per_inc_s;
    logic [SIZE-1:0] wid_inc_s;

    sm_state_e       state_q,      state_d;
    logic [SIZE-1:0] count_q,      count_d;
    logic [SIZE-1:0] period_q,     period_d;
    logic [SIZE-1:0] width_q,      width_d;
    logic [SIZE-1:0] per_cnt_q,    per_cnt_d;
    logic [SIZE-1:0] wid_cnt_q,    wid_cnt_d;
    logic            meas_valid_q, meas_valid_d;
    logic            moving_q,     moving_d;
    logic            n_done_q,     n_done_d;
    logic            stall_q,      stall_d;

    sm_pulse_monitor_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_i  (pulse_in),
        .invert_i (invert_pulse),
        .level_o  (line_s),
        .rise_o   (rise_s),
        .fall_o   (fall_s)
    );

    // Next-state logic: counters saturate, clr wins over any coincident edge.
    always_comb begin
        target_s     = (n_target == '0) ? N_C : n_target;
        count_inc_s  = (count_q   == ONES_C) ? count_q   : count_q   + ONE_C;
        per_inc_s    = (per_cnt_q == ONES_C) ? per_cnt_q : per_cnt_q + ONE_C;
        wid_inc_s    = (wid_cnt_q == ONES_C) ? wid_cnt_q : wid_cnt_q + ONE_C;
        state_d      = state_q;
        count_d      = count_q;
        period_d     = period_q;
        width_d      = width_q;
        per_cnt_d    = per_cnt_q;
        wid_cnt_d    = wid_cnt_q;
        meas_valid_d = 1'b0;
        n_done_d     = n_done_q;
        stall_d      = stall_q;
        if (clr) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            per_cnt_d = '0;
            wid_cnt_d = '0;
            n_done_d  = 1'b0;
            stall_d   = 1'b0;
        end else begin
            if (fall_s) begin
                width_d   = wid_cnt_q;
                wid_cnt_d = '0;
            end else if (line_s) begin
                wid_cnt_d = wid_inc_s;
            end else begin
                wid_cnt_d = wid_cnt_q;
            end
            if (rise_s) begin
                count_d   = count_inc_s;
                per_cnt_d = ONE_C;
                n_done_d  = n_done_q | (count_inc_s == target_s);
            end else begin
                count_d   = count_q;
                per_cnt_d = per_inc_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_d = ST_FIRST;
                    end else begin
                        per_cnt_d = '0;
                    end
                end
                ST_FIRST, ST_RUN: begin
                    // A rise landing on the timeout cycle is still a valid period.
                    if (rise_s) begin
                        state_d      = ST_RUN;
                        period_d     = per_cnt_q;
                        meas_valid_d = 1'b1;
                    end else if (per_cnt_q == TIMEOUT_C) begin
                        state_d   = ST_IDLE;
                        per_cnt_d = '0;
                        stall_d   = stall_q | ~n_done_q;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    per_cnt_d = '0;
                end
            endcase
        end
        moving_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            period_q     <= '0;
            width_q      <= '0;
            per_cnt_q    <= '0;
            wid_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            moving_q     <= 1'b0;
            n_done_q     <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_q     <= period_d;
            width_q      <= width_d;
            per_cnt_q    <= per_cnt_d;
            wid_cnt_q    <= wid_cnt_d;
            meas_valid_q <= meas_valid_d;
            moving_q     <= moving_d;
            n_done_q     <= n_done_d;
            stall_q      <= stall_d;
        end
    end

    assign count      = count_q;
    assign period     = period_q;
    assign width      = width_q;
    assign meas_valid = meas_valid_q;
    assign moving     = moving_q;
    assign n_done     = n_done_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_sm_pulse_monitor.sv
// Directed bench for sm_pulse_monitor: stimulus pushes expected measurements,
// a negedge monitor pops and compares them on every meas_valid strobe.
module tb_sm_pulse_monitor;

    localparam int SIZE  = 16;
    localparam int N_DEF = 100;
    localparam int TO    = 3000;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] width;
        logic [15:0] count;
        logic        n_done;
    } meas_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pulse_in;
    logic        invert_pulse;
    logic        clr;
    logic [15:0] n_target;
    logic [15:0] count;
    logic [15:0] period;
    logic [15:0] width;
    logic        meas_valid;
    logic        moving;
    logic        n_done;
    logic        stall;

    int    checks   = 0;
    int    failures = 0;
    meas_t exp_q[$];
    meas_t mon_e;
    int    exp_count;
    bit    exp_ndone;
    bit    fsm_active;
    int    target_eff;
    bit    seen;

    sm_pulse_monitor #(.SIZE(SIZE), .N(N_DEF), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .invert_pulse (invert_pulse),
        .clr          (clr),
        .n_target     (n_target),
        .count        (count),
        .period       (period),
        .width        (width),
        .meas_valid   (meas_valid),
        .moving       (moving),
        .n_done       (n_done),
        .stall        (stall)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_count  = 0;
        exp_ndone  = 1'b0;
        fsm_active = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        wait_clks(1);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic set_target(input int t);
        n_target   = 16'(t);
        target_eff = (t == 0) ? N_DEF : t;
    endtask

    // Change line polarity while clr is held so the transient edge is discarded.
    task automatic set_polarity(input bit inv);
        clr          = 1'b1;
        invert_pulse = inv;
        pulse_in     = inv;
        wait_clks(8);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic train(input int n, input int p, input int h, input bit inv);
        for (int i = 0; i < n; i++) begin
            pulse_in = ~inv;
            exp_count++;
            if (exp_count == target_eff) exp_ndone = 1'b1;
            if (fsm_active && (p <= TO))
                exp_q.push_back(meas_t'{16'(p), 16'(h), 16'(exp_count), exp_ndone});
            fsm_active = 1'b1;
            wait_clks(h);
            pulse_in = inv;
            wait_clks(p - h);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL meas_unexpected: got strobe period=%0d count=%0d, required none",
                         period, count);
            end else begin
                mon_e = exp_q.pop_front();
                check("meas_period", 32'(period), 32'(mon_e.period));
                check("meas_width",  32'(width),  32'(mon_e.width));
                check("meas_count",  32'(count),  32'(mon_e.count));
                check("meas_ndone",  32'(n_done), 32'(mon_e.n_done));
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        pulse_in     = 1'b0;
        invert_pulse = 1'b0;
        clr          = 1'b0;
        set_target(0);
        model_clear();
        wait_clks(3);
        check("rst_count",  32'(count),      32'd0);
        check("rst_period", 32'(period),     32'd0);
        check("rst_width",  32'(width),      32'd0);
        check("rst_valid",  32'(meas_valid), 32'd0);
        check("rst_moving", 32'(moving),     32'd0);
        check("rst_ndone",  32'(n_done),     32'd0);
        check("rst_stall",  32'(stall),      32'd0);
        rst_n = 1'b1;
        wait_clks(2);

        // Nominal train
        do_clr();
        train(10, 2000, 500, 1'b0);
        check("train_count",  32'(count),  32'd10);
        check("train_moving", 32'(moving), 32'd1);
        check("train_ndone",  32'(n_done), 32'd0);

        // Asynchronous reset in the middle of a train, then recovery
        do_clr();
        train(3, 200, 50, 1'b0);
        pulse_in = 1'b1;
        wait_clks(2);
        check("pre_rst_count", 32'(count), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_count",  32'(count),  32'd0);
        check("mid_rst_period", 32'(period), 32'd0);
        check("mid_rst_width",  32'(width),  32'd0);
        check("mid_rst_moving", 32'(moving), 32'd0);
        pulse_in = 1'b0;
        wait_clks(4);
        rst_n = 1'b1;
        model_clear();
        train(3, 200, 50, 1'b0);
        check("recover_count",  32'(count),  32'd3);
        check("recover_moving", 32'(moving), 32'd1);

        // Default target N
        do_clr();
        train(99, 20, 5, 1'b0);
        check("n99_count", 32'(count),  32'd99);
        check("n99_ndone", 32'(n_done), 32'd0);
        train(1, 20, 5, 1'b0);
        check("n100_count", 32'(count),  32'd100);
        check("n100_ndone", 32'(n_done), 32'd1);
        train(5, 20, 5, 1'b0);
        check("n105_count", 32'(count),  32'd105);
        check("n105_ndone", 32'(n_done), 32'd1);

        // Explicit target of 5
        set_target(5);
        do_clr();
        train(8, 20, 5, 1'b0);
        check("t5_count", 32'(count),  32'd8);
        check("t5_ndone", 32'(n_done), 32'd1);

        // Stall exactly TIMEOUT cycles after the third processed rise
        set_target(0);
        do_clr();
        train(2, 200, 50, 1'b0);
        pulse_in = 1'b1;
        exp_count++;
        exp_q.push_back(meas_t'{16'd200, 16'd50, 16'(exp_count), 1'b0});
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (count == 16'd3) seen = 1'b1;
        end
        check("stall_rise3_seen", 32'(seen), 32'd1);
        pulse_in = 1'b0;
        repeat (TO - 1) @(negedge clk);
        check("stall_before", 32'(stall),  32'd0);
        check("moving_before", 32'(moving), 32'd1);
        @(negedge clk);
        check("stall_at_to",  32'(stall),  32'd1);
        check("moving_at_to", 32'(moving), 32'd0);
        fsm_active = 1'b0;

        // Timeout after the target was reached is not a stall
        set_target(2);
        do_clr();
        train(3, 200, 50, 1'b0);
        wait_clks(TO + 20);
        check("done_stall",  32'(stall),  32'd0);
        check("done_ndone",  32'(n_done), 32'd1);
        check("done_moving", 32'(moving), 32'd0);
        set_target(0);

        // Active-low input
        set_polarity(1'b1);
        train(4, 2000, 500, 1'b1);
        check("inv_count", 32'(count), 32'd4);
        set_polarity(1'b0);

        // clr coincident with a rise
        do_clr();
        pulse_in = 1'b1;
        wait_clks(3);
        clr = 1'b1;
        wait_clks(1);
        clr = 1'b0;
        check("clr_rise_count",  32'(count),  32'd0);
        check("clr_rise_moving", 32'(moving), 32'd0);
        wait_clks(5);
        pulse_in = 1'b0;
        wait_clks(10);
        check("clr_rise_count2", 32'(count), 32'd0);
        model_clear();

        // Shortest period
        do_clr();
        train(4, 2, 1, 1'b0);
        wait_clks(6);
        check("p2_count", 32'(count), 32'd4);

        // Period equal to TIMEOUT: the rise wins
        do_clr();
        train(2, TO, 100, 1'b0);
        check("pto_moving", 32'(moving), 32'd1);
        check("pto_stall",  32'(stall),  32'd0);

        // Period one past TIMEOUT: timeout, stall, no measurement
        do_clr();
        train(2, TO + 1, 100, 1'b0);
        check("pto1_count",  32'(count),  32'd2);
        check("pto1_stall",  32'(stall),  32'd1);
        check("pto1_moving", 32'(moving), 32'd1);

        wait_clks(10);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
